ahb_lite_fir_master: RTL and testbench

AHB-Lite initiator that drives the team's 16-bit FIR filter peripheral. A host-side handshake supplies a coefficient set or an input sample. The block then issues the matching AHB-Lite write and read transfers: coefficient loads, sample writes, status polling and result reads. It returns each filtered result on a valid pulse. It sits between a host/sequencer and the FIR peripheral's AHB-Lite slave port and is the only master on that bus.

---
 rtl/ahb_lite_fir_master_if.sv | 21 ++
 rtl/ahb_lite_fir_master.sv | 236 +++++++++++++++++++++++
 tb/tb_ahb_lite_fir_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_fir_master_if.sv
// AHB-Lite bus between the FIR master and the FIR peripheral's slave port.
interface ahb_lite_fir_master_if;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic        hsize;
  logic        hwrite;
  logic [15:0] hwdata;
  logic [15:0] hrdata;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hwdata,
    input  hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hwdata,
    output hrdata, hresp
  );
endinterface

// File: rtl/ahb_lite_fir_master.sv
// AHB-Lite initiator for the 16-bit FIR peripheral: coefficient loads, sample writes, status polls, result reads.
// Optional macro FIR_MASTER_TIMEOUT_EN bounds each poll loop to POLL_LIMIT status reads.
module ahb_lite_fir_master #(
  parameter int POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        coeff_load,
  input  logic [15:0] coeff0,
  input  logic [15:0] coeff1,
  input  logic [15:0] coeff2,
  input  logic [15:0] coeff3,
  output logic        load_busy,
  output logic        load_done,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic        result_valid,
  output logic [15:0] result_data,
  output logic        result_err,
  output logic        bus_err,
  output logic        timeout,
  input  logic        err_clear,
  ahb_lite_fir_master_if.master ahb
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_C_WR, ST_C_CONF, ST_C_POLL, ST_S_WR, ST_S_POLL, ST_S_READ, ST_ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic        phase_reg, phase_next;  // 0 = address phase, 1 = data phase
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] coeff_in [4];
  logic [15:0] coeff_reg [4];
  logic [15:0] sample_reg;
  logic        stat_err_reg;
  logic [15:0] result_data_reg;
  logic        result_err_reg;
  logic        result_valid_reg;
  logic        load_done_reg;
  logic        bus_err_reg;

  logic accept_coeff, accept_sample, set_result, set_err, clr_err, cap_stat;
  logic poll_more, poll_hit, load_done_next;
  logic xfer, addr_ph, data_ph;
  logic [3:0]  xfer_addr;
  logic        xfer_write;
  logic [15:0] xfer_wdata;

  assign coeff_in[0] = coeff0;
  assign coeff_in[1] = coeff1;
  assign coeff_in[2] = coeff2;
  assign coeff_in[3] = coeff3;

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    idx_next       = idx_reg;
    accept_coeff   = 1'b0;
    accept_sample  = 1'b0;
    set_result     = 1'b0;
    set_err        = 1'b0;
    clr_err        = 1'b0;
    cap_stat       = 1'b0;
    poll_more      = 1'b0;
    load_done_next = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (coeff_load) begin
          accept_coeff = 1'b1;
          state_next   = ST_C_WR;
          phase_next   = 1'b0;
          idx_next     = 2'd0;
        end else if (sample_valid) begin
          accept_sample = 1'b1;
          state_next    = ST_S_WR;
          phase_next    = 1'b0;
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          clr_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (ahb.hresp) begin
            set_err    = 1'b1;
            state_next = ST_ERROR;
          end else begin
            case (state_reg)
              ST_C_WR: begin
                if (idx_reg == 2'd3) state_next = ST_C_CONF;
                else                 idx_next   = idx_reg + 2'd1;
              end
              ST_C_CONF: state_next = ST_C_POLL;
              ST_C_POLL: begin
                if (ahb.hrdata == 16'h0000) begin
                  state_next     = ST_IDLE;
                  load_done_next = 1'b1;
                end else begin
                  poll_more = 1'b1;
                end
              end
              ST_S_WR: state_next = ST_S_POLL;
              ST_S_POLL: begin
                cap_stat = 1'b1;
                if (!ahb.hrdata[0]) state_next = ST_S_READ;
                else                poll_more  = 1'b1;
              end
              ST_S_READ: begin
                state_next = ST_IDLE;
                set_result = 1'b1;
              end
              default: ;
            endcase
            // A poll loop that has used its budget stops instead of issuing another read
            if (poll_more && poll_hit) begin
              set_err    = 1'b1;
              state_next = ST_ERROR;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg        <= ST_IDLE;
      phase_reg        <= 1'b0;
      idx_reg          <= 2'd0;
      sample_reg       <= '0;
      stat_err_reg     <= 1'b0;
      result_data_reg  <= '0;
      result_err_reg   <= 1'b0;
      result_valid_reg <= 1'b0;
      load_done_reg    <= 1'b0;
      bus_err_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) coeff_reg[i] <= '0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      idx_reg          <= idx_next;
      result_valid_reg <= set_result;
      load_done_reg    <= load_done_next;
      if (accept_coeff) begin
        for (int i = 0; i < 4; i++) coeff_reg[i] <= coeff_in[i];
      end
      if (accept_sample) sample_reg <= sample_data;
      if (cap_stat) stat_err_reg <= ahb.hrdata[8];
      if (set_result) begin
        result_data_reg <= ahb.hrdata;
        result_err_reg  <= stat_err_reg;
      end
      if (clr_err)      bus_err_reg <= 1'b0;
      else if (set_err) bus_err_reg <= 1'b1;
    end
  end

`ifdef FIR_MASTER_TIMEOUT_EN
  localparam int PCW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);
  logic [PCW-1:0] poll_cnt_reg;
  logic           timeout_reg;

  // Counter holds 1 outside the loop so it already counts the first read on entry
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      poll_cnt_reg <= PCW'(1);
      timeout_reg  <= 1'b0;
    end else begin
      if (!(state_reg inside {ST_C_POLL, ST_S_POLL})) poll_cnt_reg <= PCW'(1);
      else if (poll_more && !poll_hit)                poll_cnt_reg <= poll_cnt_reg + 1'b1;
      if (clr_err)                    timeout_reg <= 1'b0;
      else if (poll_more && poll_hit) timeout_reg <= 1'b1;
    end
  end

  assign poll_hit = (poll_cnt_reg == PCW'(POLL_LIMIT));
  assign timeout  = timeout_reg;
`else
  localparam int unused_poll_limit = POLL_LIMIT;
  assign poll_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign xfer    = state_reg inside {ST_C_WR, ST_C_CONF, ST_C_POLL, ST_S_WR, ST_S_POLL, ST_S_READ};
  assign addr_ph = xfer && !phase_reg;
  assign data_ph = xfer && phase_reg;

  always_comb begin
    xfer_addr  = 4'h0;
    xfer_write = 1'b0;
    xfer_wdata = 16'h0000;
    case (state_reg)
      ST_C_WR: begin
        xfer_addr  = 4'h6 + {1'b0, idx_reg, 1'b0};
        xfer_write = 1'b1;
        xfer_wdata = coeff_reg[idx_reg];
      end
      ST_C_CONF: begin
        xfer_addr  = 4'hE;
        xfer_write = 1'b1;
        xfer_wdata = 16'h0001;
      end
      ST_C_POLL: xfer_addr = 4'hE;
      ST_S_WR: begin
        xfer_addr  = 4'h4;
        xfer_write = 1'b1;
        xfer_wdata = sample_reg;
      end
      ST_S_POLL: xfer_addr = 4'h0;
      ST_S_READ: xfer_addr = 4'h2;
      default: ;
    endcase
  end

  assign ahb.hsel   = addr_ph;
  assign ahb.htrans = addr_ph ? 2'b10 : 2'b00;
  assign ahb.haddr  = addr_ph ? xfer_addr : 4'h0;
  assign ahb.hsize  = addr_ph;
  assign ahb.hwrite = addr_ph && xfer_write;
  assign ahb.hwdata = data_ph ? xfer_wdata : 16'h0000;

  assign load_busy    = state_reg inside {ST_C_WR, ST_C_CONF, ST_C_POLL};
  assign load_done    = load_done_reg;
  assign sample_ready = (state_reg == ST_IDLE) && !coeff_load;
  assign result_valid = result_valid_reg;
  assign result_data  = result_data_reg;
  assign result_err   = result_err_reg;
  assign bus_err      = bus_err_reg;
endmodule

// File: tb/tb_ahb_lite_fir_master.sv
// Bench for ahb_lite_fir_master: scripted zero-wait FIR slave plus a transfer-list reference model.
module tb_ahb_lite_fir_master;
  localparam int PL = 3;
`ifdef FIR_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        coeff_load, sample_valid, err_clear;
  logic [15:0] coeff0, coeff1, coeff2, coeff3, sample_data;
  logic        load_busy, load_done, sample_ready, result_valid, result_err, bus_err, timeout;
  logic [15:0] result_data;

  ahb_lite_fir_master_if bus();

  ahb_lite_fir_master #(.POLL_LIMIT(PL)) dut (
    .clk(clk), .n_rst(n_rst),
    .coeff_load(coeff_load), .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .load_busy(load_busy), .load_done(load_done),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .result_valid(result_valid), .result_data(result_data), .result_err(result_err),
    .bus_err(bus_err), .timeout(timeout), .err_clear(err_clear),
    .ahb(bus)
  );

  always #5 clk = ~clk;

  // Peripheral model: status busy for cfg_busy reads, load-confirm nonzero for cfg_busy reads
  logic        dp_act = 1'b0, dp_wr = 1'b0;
  logic [3:0]  dp_addr = 4'h0;
  int          stat_reads = 0, conf_reads = 0;
  int          cfg_busy = 0;
  bit          cfg_err = 1'b0, cfg_flip = 1'b0, cfg_hr_en = 1'b0;
  logic [15:0] cfg_result = 16'h0;
  logic [3:0]  cfg_hr_addr = 4'h0;
  logic [15:0] rd_val;

  always @(posedge clk) begin
    dp_act  <= bus.hsel && bus.htrans == 2'b10;
    dp_wr   <= bus.hwrite;
    dp_addr <= bus.haddr;
    if (dp_act && dp_wr && dp_addr == 4'h4)       stat_reads <= 0;
    else if (dp_act && !dp_wr && dp_addr == 4'h0) stat_reads <= stat_reads + 1;
    if (dp_act && dp_wr && dp_addr == 4'hE)       conf_reads <= 0;
    else if (dp_act && !dp_wr && dp_addr == 4'hE) conf_reads <= conf_reads + 1;
  end

  always_comb begin
    rd_val = 16'h0000;
    if (dp_addr == 4'h0) begin
      rd_val[0] = (stat_reads < cfg_busy);
      rd_val[8] = cfg_err ^ (cfg_flip && (stat_reads < cfg_busy));
    end else if (dp_addr == 4'h2) begin
      rd_val = cfg_result;
    end else if (dp_addr == 4'hE) begin
      rd_val[0] = (conf_reads < cfg_busy);
    end else begin
      rd_val = 16'hA5A5;
    end
  end

  assign bus.hrdata = dp_act ? rd_val : 16'hDEAD;
  assign bus.hresp  = dp_act && cfg_hr_en && dp_addr == cfg_hr_addr;

  int n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed transfers as {write, addr, wdata}
  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  bit          pend = 1'b0;
  logic        pend_wr;
  logic [3:0]  pend_addr;

  task automatic log_cycle();
    if (pend) begin
      check("dphase_hsel", bus.hsel, 0);
      check("dphase_htrans", bus.htrans, 0);
      obs_q.push_back({pend_wr, pend_addr, pend_wr ? bus.hwdata : 16'h0000});
      pend = 1'b0;
    end
    if (bus.hsel && bus.htrans == 2'b10) begin
      check("hsize", bus.hsize, 1);
      pend      = 1'b1;
      pend_wr   = bus.hwrite;
      pend_addr = bus.haddr;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_htrans"}, bus.htrans, 0);
    check({pfx, "_hsel"}, bus.hsel, 0);
    check({pfx, "_haddr"}, bus.haddr, 0);
    check({pfx, "_hwrite"}, bus.hwrite, 0);
    check({pfx, "_hsize"}, bus.hsize, 0);
    check({pfx, "_hwdata"}, bus.hwdata, 0);
    check({pfx, "_load_busy"}, load_busy, 0);
    check({pfx, "_load_done"}, load_done, 0);
    check({pfx, "_result_valid"}, result_valid, 0);
    check({pfx, "_result_data"}, result_data, 0);
    check({pfx, "_result_err"}, result_err, 0);
    check({pfx, "_bus_err"}, bus_err, 0);
    check({pfx, "_timeout"}, timeout, 0);
    check({pfx, "_sample_ready"}, sample_ready, 1);
  endtask

  task automatic do_op(input bit is_coeff, input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] c2, input logic [15:0] c3, input logic [15:0] smp,
                       input int nbusy, input bit serr, input bit flip, input logic [15:0] res,
                       input bit hr_en, input logic [3:0] hr_addr, input bit both);
    logic [20:0] full_q[$];
    int n_polls, outcome, lat, cyc;
    bit to_hit;
    // Reference: nominal transfer list, cut at the first hresp target or at the poll budget
    if (is_coeff) begin
      full_q.push_back({1'b1, 4'h6, c0});
      full_q.push_back({1'b1, 4'h8, c1});
      full_q.push_back({1'b1, 4'hA, c2});
      full_q.push_back({1'b1, 4'hC, c3});
      full_q.push_back({1'b1, 4'hE, 16'h0001});
    end else begin
      full_q.push_back({1'b1, 4'h4, smp});
    end
    n_polls = nbusy + 1;
    to_hit  = 1'b0;
    if (TO_EN && n_polls > PL) begin
      n_polls = PL;
      to_hit  = 1'b1;
    end
    for (int i = 0; i < n_polls; i++) full_q.push_back({1'b0, is_coeff ? 4'hE : 4'h0, 16'h0000});
    if (!is_coeff && !to_hit) full_q.push_back({1'b0, 4'h2, 16'h0000});
    exp_q.delete();
    outcome = to_hit ? 2 : 0;
    for (int i = 0; i < full_q.size(); i++) begin
      exp_q.push_back(full_q[i]);
      if (hr_en && full_q[i][19:16] == hr_addr) begin
        outcome = 1;
        break;
      end
    end
    lat = 2 * exp_q.size() + 1;

    cfg_busy = nbusy; cfg_err = serr; cfg_flip = flip; cfg_result = res;
    cfg_hr_en = hr_en; cfg_hr_addr = hr_addr;
    obs_q.delete();
    pend = 1'b0;
    coeff0 = c0; coeff1 = c1; coeff2 = c2; coeff3 = c3; sample_data = smp;
    coeff_load   = is_coeff;
    sample_valid = !is_coeff || both;
    #1;
    check("sample_ready_cmd", sample_ready, !is_coeff);
    @(negedge clk);
    coeff_load = 1'b0; sample_valid = 1'b0;
    coeff0 = 16'($urandom); coeff1 = 16'($urandom); coeff2 = 16'($urandom);
    coeff3 = 16'($urandom); sample_data = 16'($urandom);
    cyc = 1;
    while (1) begin
      log_cycle();
      if (cyc == 1) check("load_busy_start", load_busy, is_coeff);
      if (result_valid || load_done || bus_err || cyc >= 300) break;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, lat);
    check("xfer_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("xfer%0d", i), obs_q[i], exp_q[i]);
    if (outcome == 0) begin
      check("load_done", load_done, is_coeff);
      check("result_valid", result_valid, !is_coeff);
      check("bus_err_ok", bus_err, 0);
      if (!is_coeff) begin
        check("result_data", result_data, res);
        check("result_err", result_err, serr);
      end else begin
        check("load_busy_end", load_busy, 0);
      end
      check("ready_after", sample_ready, 1);
    end else begin
      check("bus_err", bus_err, 1);
      check("timeout", timeout, outcome == 2);
      check("no_result", result_valid, 0);
      check("no_done", load_done, 0);
      check("err_ready", sample_ready, 0);
      check("err_htrans", bus.htrans, 0);
      err_clear = 1'b1;
      sample_valid = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      sample_valid = 1'b0;
      #1;
      check("clr_ready", sample_ready, 1);
      check("clr_bus_err", bus_err, 0);
      check("clr_timeout", timeout, 0);
      check("clr_no_xfer", bus.htrans, 0);
    end
    $display("op %s busy=%0d hresp=%0d@%h lat=%0d exp_lat=%0d outcome=%0d xfers=%0d",
             is_coeff ? "coeff" : "sample", nbusy, hr_en, hr_addr, cyc, lat, outcome, obs_q.size());
  endtask

  initial begin
    n_rst = 1'b0; coeff_load = 1'b0; sample_valid = 1'b0; err_clear = 1'b0;
    coeff0 = '0; coeff1 = '0; coeff2 = '0; coeff3 = '0; sample_data = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    n_rst = 1'b1;
    @(negedge clk);

    do_op(1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0, 0, 0, 0, 16'h0, 0, 4'h0, 0);
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 2, 0, 0, 16'hBEEF, 0, 4'h0, 0);
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5555, 0, 1, 0, 16'h0F0F, 0, 4'h0, 0);
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 0, 0, 0, 16'h1111, 1, 4'h4, 0);
    do_op(1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h9999, 1, 0, 0, 16'h0, 0, 4'h0, 1);
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4321, 3, 0, 1, 16'h2468, 0, 4'h0, 0);

    for (int k = 0; k < 40; k++) begin
      bit         isc, hr;
      int         nb, s;
      logic [3:0] ha;
      isc = ($urandom_range(0, 2) == 0);
      nb  = $urandom_range(0, 4);
      hr  = ($urandom_range(0, 4) == 0);
      if (isc) begin
        ha = 4'(6 + 2 * $urandom_range(0, 4));
      end else begin
        s  = $urandom_range(0, 2);
        ha = (s == 0) ? 4'h4 : ((s == 1) ? 4'h0 : 4'h2);
      end
      do_op(isc, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            hr, ha, 1'($urandom_range(0, 1)));
    end

`ifdef FIR_MASTER_TIMEOUT_EN
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0BAD, 10, 0, 0, 16'h0, 0, 4'h0, 0);
    do_op(1, 16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 7, 0, 0, 16'h0, 0, 4'h0, 0);
`endif

    // Reset while the sample sequence is polling a busy peripheral
    cfg_busy = 50; cfg_hr_en = 1'b0;
    sample_data = 16'h3C3C; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    $display("op reset-mid-poll htrans=%0h sample_ready=%0d", bus.htrans, sample_ready);
    n_rst = 1'b1;
    @(negedge clk);
    do_op(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0042, 1, 0, 0, 16'hCAFE, 0, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
